// File: rtl/keccak_pkg.sv
// Shared types, constants and lookup helpers for the Keccak padding/absorb front-end.
package keccak_pkg;

  localparam int LANE_W = 64;
  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;

  typedef enum logic [2:0] {
    CM_SHA3_224 = 3'd0,
    CM_SHA3_256 = 3'd1,
    CM_SHA3_384 = 3'd2,
    CM_SHA3_512 = 3'd3,
    CM_SHAKE128 = 3'd4,
    CM_SHAKE256 = 3'd5
  } cmode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_PAD    = 2'd2,
    ST_DRAIN  = 2'd3
  } pad_state_e;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [4:0]        idx;
    logic              block_last;
    logic              msg_last;
  } lane_rec_t;

  function automatic logic [4:0] RATE_LANES(input cmode_e cm);
    case (cm)
      CM_SHA3_224: return 5'd18;
      CM_SHA3_256: return 5'd17;
      CM_SHA3_384: return 5'd13;
      CM_SHA3_512: return 5'd9;
      CM_SHAKE128: return 5'd21;
      CM_SHAKE256: return 5'd17;
      default:     return 5'd17;
    endcase
  endfunction

  function automatic logic [7:0] DOMAIN_BYTE(input cmode_e cm);
    return (cm == CM_SHAKE128 || cm == CM_SHAKE256) ? DOMAIN_SHAKE : DOMAIN_SHA3;
  endfunction

  function automatic logic cmode_is_valid(input logic [2:0] cm);
    return cm <= 3'd5;
  endfunction

endpackage

// File: rtl/keccak_lane_fifo.sv
// First-word-fall-through lane FIFO; head record reads as zero while empty.
module keccak_lane_fifo
  import keccak_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      reset_ni,
  input  logic      push_i,
  input  lane_rec_t wdata_i,
  input  logic      pop_i,
  output lane_rec_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  lane_rec_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == FULL_CNT);
  assign w_pop   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push  = push_i && (!full_o || w_pop);
  assign rdata_o = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keccak_pad_absorber.sv
// Packs message words into 64-bit lanes, applies domain byte and pad10*1, emits rate lanes per block.
// Optional KECCAK_PAD_STATS_EN adds msg_bytes_o / blk_cnt_o statistics outputs.
module keccak_pad_absorber
  import keccak_pkg::*;
#(
  parameter int DIN_W     = 32,
  parameter int OUT_DEPTH = 4,
  localparam int BCW      = $clog2(DIN_W / 8) + 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [2:0]       cmode_i,
  input  logic             start_i,
  input  logic [DIN_W-1:0] din_i,
  input  logic             din_valid_i,
  input  logic             din_last_i,
  input  logic [BCW-1:0]   din_bytes_i,
  output logic             din_ready_o,
  output logic [63:0]      lane_o,
  output logic [4:0]       lane_idx_o,
  output logic             block_last_o,
  output logic             msg_last_o,
  output logic             lane_valid_o,
  input  logic             lane_ready_i,
  output logic             busy_o,
  output logic             err_o
`ifdef KECCAK_PAD_STATS_EN
  ,
  output logic [31:0]      msg_bytes_o,
  output logic [15:0]      blk_cnt_o
`endif
);

  localparam int WB = DIN_W / 8;
  localparam logic [LANE_W-1:0] PAD_MSB = {8'h80, 56'h0};

  pad_state_e        r_state;
  pad_state_e        w_state_next;
  cmode_e            r_mode;
  logic [LANE_W-1:0] r_lane;
  logic [LANE_W-1:0] w_lane_next;
  logic [2:0]        r_off;
  logic [2:0]        w_off_next;
  logic [4:0]        r_idx;
  logic [4:0]        w_idx_next;
  logic [4:0]        w_idx_wrap;
  logic [4:0]        w_rate;
  logic              r_err;
  logic              w_err_next;
  logic              w_start_ok;
  logic [7:0]        w_dom;
  logic [BCW-1:0]    w_bytes_clamped;
  logic [3:0]        w_nb;
  logic [3:0]        w_new_off;
  logic [DIN_W-1:0]  w_word_masked;
  logic [LANE_W-1:0] w_combined;
  logic [LANE_W-1:0] w_dom_ins;
  logic [LANE_W-1:0] w_pad_bit;
  logic              w_last_lane;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_can_push;
  logic              w_accept;
  logic              w_push;
  lane_rec_t         w_push_rec;
  lane_rec_t         w_head;

  assign w_rate      = RATE_LANES(r_mode);
  assign w_dom       = DOMAIN_BYTE(r_mode);
  assign w_last_lane = (r_idx == w_rate - 5'd1);
  assign w_idx_wrap  = w_last_lane ? 5'd0 : r_idx + 5'd1;
  assign w_pad_bit   = w_last_lane ? PAD_MSB : '0;

  assign w_pop      = lane_ready_i && !w_empty;
  assign w_can_push = !w_full || w_pop;
  assign w_accept   = (r_state == ST_ABSORB) && din_valid_i && w_can_push;

  assign w_bytes_clamped = (din_bytes_i > BCW'(WB)) ? BCW'(WB) : din_bytes_i;
  assign w_nb            = din_last_i ? 4'(w_bytes_clamped) : 4'(WB);

  for (genvar gi = 0; gi < WB; gi++) begin : g_byte_mask
    assign w_word_masked[8*gi +: 8] = (4'(gi) < w_nb) ? din_i[8*gi +: 8] : 8'h00;
  end

  assign w_combined = r_lane | (LANE_W'(w_word_masked) << {r_off, 3'b000});
  assign w_new_off  = {1'b0, r_off} + w_nb;
  assign w_dom_ins  = LANE_W'(w_dom) << {w_new_off[2:0], 3'b000};

  // msg_last marks every lane pushed from the last word onward that lies in the final block.
  always_comb begin
    w_state_next = r_state;
    w_lane_next  = r_lane;
    w_off_next   = r_off;
    w_idx_next   = r_idx;
    w_err_next   = 1'b0;
    w_start_ok   = 1'b0;
    w_push       = 1'b0;
    w_push_rec   = '0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (cmode_is_valid(cmode_i)) begin
            w_start_ok   = 1'b1;
            w_state_next = ST_ABSORB;
            w_lane_next  = '0;
            w_off_next   = 3'd0;
            w_idx_next   = 5'd0;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      ST_ABSORB: begin
        if (w_accept) begin
          w_push_rec.idx        = r_idx;
          w_push_rec.block_last = w_last_lane;
          if (!din_last_i) begin
            if (w_new_off[3]) begin
              w_push             = 1'b1;
              w_push_rec.lane    = w_combined;
              w_push_rec.msg_last = 1'b0;
              w_lane_next        = '0;
              w_off_next         = 3'd0;
              w_idx_next         = w_idx_wrap;
            end else begin
              w_lane_next = w_combined;
              w_off_next  = w_new_off[2:0];
            end
          end else if (!w_new_off[3]) begin
            w_push              = 1'b1;
            w_push_rec.lane     = w_combined | w_dom_ins | w_pad_bit;
            w_push_rec.msg_last = 1'b1;
            w_lane_next         = '0;
            w_off_next          = 3'd0;
            w_idx_next          = w_idx_wrap;
            w_state_next        = w_last_lane ? ST_DRAIN : ST_PAD;
          end else begin
            // Lane filled exactly; the domain byte opens the next lane (possibly a new block).
            w_push              = 1'b1;
            w_push_rec.lane     = w_combined;
            w_push_rec.msg_last = !w_last_lane;
            w_lane_next         = LANE_W'(w_dom);
            w_off_next          = 3'd0;
            w_idx_next          = w_idx_wrap;
            w_state_next        = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (w_can_push) begin
          w_push                = 1'b1;
          w_push_rec.lane       = r_lane | w_pad_bit;
          w_push_rec.idx        = r_idx;
          w_push_rec.block_last = w_last_lane;
          w_push_rec.msg_last   = 1'b1;
          w_lane_next           = '0;
          w_idx_next            = w_idx_wrap;
          if (w_last_lane) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
      r_mode  <= CM_SHA3_224;
      r_lane  <= '0;
      r_off   <= 3'd0;
      r_idx   <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lane  <= w_lane_next;
      r_off   <= w_off_next;
      r_idx   <= w_idx_next;
      r_err   <= w_err_next;
      if (w_start_ok) begin
        r_mode <= cmode_e'(cmode_i);
      end
    end
  end

  keccak_lane_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (w_push),
    .wdata_i  (w_push_rec),
    .pop_i    (lane_ready_i),
    .rdata_o  (w_head),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );

  assign din_ready_o  = (r_state == ST_ABSORB) && w_can_push;
  assign lane_o       = w_head.lane;
  assign lane_idx_o   = w_head.idx;
  assign block_last_o = w_head.block_last;
  assign msg_last_o   = w_head.msg_last;
  assign lane_valid_o = !w_empty;
  assign busy_o       = (r_state != ST_IDLE) || !w_empty;
  assign err_o        = r_err;

`ifdef KECCAK_PAD_STATS_EN
  logic [31:0] r_msg_bytes;
  logic [15:0] r_blk_cnt;
  logic [32:0] w_bytes_sum;

  assign w_bytes_sum = {1'b0, r_msg_bytes} + 33'(w_nb);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_msg_bytes <= '0;
      r_blk_cnt   <= '0;
    end else if (w_start_ok) begin
      r_msg_bytes <= '0;
      r_blk_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_msg_bytes <= w_bytes_sum[32] ? 32'hFFFF_FFFF : w_bytes_sum[31:0];
      end
      if (w_push && w_push_rec.block_last) begin
        r_blk_cnt <= r_blk_cnt + 16'd1;
      end
    end
  end

  assign msg_bytes_o = r_msg_bytes;
  assign blk_cnt_o   = r_blk_cnt;
`endif

endmodule

// File: tb/tb_keccak_pad_absorber.sv
// Randomised bench: expected lanes come from a padded-byte-array model of each message.
module tb_keccak_pad_absorber;

  localparam int DIN_W     = 32;
  localparam int OUT_DEPTH = 4;
  localparam int WB        = DIN_W / 8;
  localparam int BCW       = $clog2(WB) + 1;
  localparam int RATES [6] = '{18, 17, 13, 9, 21, 17};

  typedef struct {
    logic [63:0] lane;
    int          idx;
    bit          bl;
    bit          ml;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       cmode;
  logic             start;
  logic [DIN_W-1:0] din;
  logic             din_valid;
  logic             din_last;
  logic [BCW-1:0]   din_bytes;
  logic             din_ready;
  logic [63:0]      lane;
  logic [4:0]       lane_idx;
  logic             block_last;
  logic             msg_last;
  logic             lane_valid;
  logic             lane_ready;
  logic             busy;
  logic             err;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stall    = 1'b1;
  exp_t exp_q[$];

  keccak_pad_absorber #(
    .DIN_W     (DIN_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .cmode_i      (cmode),
    .start_i      (start),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_last_i   (din_last),
    .din_bytes_i  (din_bytes),
    .din_ready_o  (din_ready),
    .lane_o       (lane),
    .lane_idx_o   (lane_idx),
    .block_last_o (block_last),
    .msg_last_o   (msg_last),
    .lane_valid_o (lane_valid),
    .lane_ready_i (lane_ready),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Pad the message as a byte array, then slice into little-endian lanes.
  function automatic void model(input int mode, input byte unsigned msg[$], input int last_nb,
                                output exp_t q[$]);
    int n, r, nblk, nl, first_ml, fin_start;
    byte unsigned pb[];
    logic [63:0] v;
    exp_t e;
    q = {};
    n = msg.size();
    r = RATES[mode];
    nblk = n / (8 * r) + 1;
    nl = nblk * r;
    pb = new[nl * 8];
    foreach (pb[i]) pb[i] = 8'h00;
    foreach (msg[i]) pb[i] = msg[i];
    pb[n] = (mode >= 4) ? 8'h1F : 8'h06;
    pb[nl*8-1] = pb[nl*8-1] | 8'h80;
    first_ml = (n - last_nb) / 8;
    fin_start = (nblk - 1) * r;
    for (int l = 0; l < nl; l++) begin
      v = '0;
      for (int b = 0; b < 8; b++) v[8*b +: 8] = pb[8*l+b];
      e.lane = v;
      e.idx = l % r;
      e.bl = ((l % r) == r - 1);
      e.ml = (l >= first_ml) && (l >= fin_start);
      q.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    lane_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (reset_n && lane_valid && lane_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_lane: got %h expected no lane", lane);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("lane_data", lane, e.lane);
        check("lane_idx", 64'(lane_idx), 64'(e.idx));
        check("block_last", 64'(block_last), 64'(e.bl));
        check("msg_last", 64'(msg_last), 64'(e.ml));
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 3000);
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic send_msg(input int mode, input byte unsigned msg[$], input bit extra_empty);
    int n, nwords, last_nb, t;
    exp_t q[$];
    logic [DIN_W-1:0] word;
    n = msg.size();
    if (n == 0) begin
      nwords = 1; last_nb = 0;
    end else if (n % WB != 0) begin
      nwords = n / WB + 1; last_nb = n % WB;
    end else if (extra_empty) begin
      nwords = n / WB + 1; last_nb = 0;
    end else begin
      nwords = n / WB; last_nb = WB;
    end
    wait_idle();
    model(mode, msg, last_nb, q);
    foreach (q[i]) exp_q.push_back(q[i]);
    $display("msg mode=%0d bytes=%0d words=%0d last_bytes=%0d lanes=%0d", mode, n, nwords, last_nb, q.size());
    @(posedge clk); #1;
    start = 1'b1;
    cmode = 3'(mode);
    @(posedge clk); #1;
    start = 1'b0;
    cmode = 3'($urandom);
    for (int w = 0; w < nwords; w++) begin
      word = DIN_W'({$urandom, $urandom});
      for (int b = 0; b < WB; b++) begin
        if (w * WB + b < n) word[8*b +: 8] = msg[w*WB+b];
      end
      din = word;
      din_valid = 1'b1;
      din_last = (w == nwords - 1);
      din_bytes = (w == nwords - 1) ? BCW'(last_nb) : BCW'($urandom_range(0, WB));
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!din_ready && t < 2000);
      if (!din_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got din_ready=0 expected 1 at word %0d", w);
        din_valid = 1'b0;
        din_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask

  initial begin
    byte unsigned m[$];
    exp_t q[$];
    reset_n = 1'b0;
    cmode = 3'd0;
    start = 1'b0;
    din = '0;
    din_valid = 1'b0;
    din_last = 1'b0;
    din_bytes = '0;
    lane_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lane_valid", 64'(lane_valid), 64'd0);
    check("rst_din_ready", 64'(din_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_lane", lane, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Hand-computed values that pin the model.
    m = {};
    model(1, m, 0, q);
    check("model_empty_count", 64'(q.size()), 64'd17);
    check("model_empty_lane0", q[0].lane, 64'h06);
    check("model_empty_lane16", q[16].lane, 64'h8000_0000_0000_0000);
    check("model_empty_ml", 64'(q[3].ml), 64'd1);
    m = {};
    for (int i = 0; i < 71; i++) m.push_back(8'hAA);
    model(3, m, 3, q);
    check("model_512_count", 64'(q.size()), 64'd9);
    check("model_512_lane8", q[8].lane, 64'h86AA_AAAA_AAAA_AAAA);
    m = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    model(4, m, 1, q);
    check("model_shake_lane0", q[0].lane, 64'h0000_1F05_0403_0201);
    check("model_shake_lane20", q[20].lane, 64'h8000_0000_0000_0000);
    m = {};
    for (int i = 0; i < 136; i++) m.push_back(8'(i));
    model(1, m, 4, q);
    check("model_136_count", 64'(q.size()), 64'd34);
    check("model_136_blk1_ml", 64'(q[16].ml), 64'd0);
    check("model_136_blk2_lane0", q[17].lane, 64'h06);

    stall = 1'b0;
    m = {};
    send_msg(1, m, 1'b0);
    m = {};
    for (int i = 0; i < 71; i++) m.push_back(8'hAA);
    send_msg(3, m, 1'b0);
    m = {};
    for (int i = 0; i < 136; i++) m.push_back(8'($urandom));
    send_msg(1, m, 1'b0);
    send_msg(1, m, 1'b1);
    m = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_msg(4, m, 1'b0);

    for (int k = 0; k < 14; k++) begin
      int mode, n;
      mode = $urandom_range(0, 5);
      n = $urandom_range(0, 200);
      m = {};
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      send_msg(mode, m, 1'($urandom));
    end

    // Back-pressure: hold lane_ready low mid-block and expect din_ready to drop.
    wait_idle();
    m = {};
    for (int i = 0; i < 150; i++) m.push_back(8'($urandom));
    fork
      send_msg(0, m, 1'b0);
      begin
        repeat (12) @(negedge clk);
        stall = 1'b1;
        repeat (20) @(negedge clk);
        check("stall_din_ready", 64'(din_ready), 64'd0);
        check("stall_lane_valid", 64'(lane_valid), 64'd1);
        stall = 1'b0;
      end
    join

    // Reset mid-block, then an invalid-mode start.
    wait_idle();
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    cmode = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    din = DIN_W'($urandom);
    din_valid = 1'b1;
    din_last = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_lane_valid", 64'(lane_valid), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_lane_valid", 64'(lane_valid), 64'd0);
    check("mid_rst_lane", lane, 64'd0);
    check("mid_rst_flags", 64'({lane_idx, block_last, msg_last}), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_din_ready", 64'(din_ready), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    start = 1'b1;
    cmode = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("bad_mode_err", 64'(err), 64'd1);
    check("bad_mode_busy", 64'(busy), 64'd0);
    check("bad_mode_din_ready", 64'(din_ready), 64'd0);
    @(negedge clk);
    check("err_one_cycle", 64'(err), 64'd0);
    stall = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_lane_valid", 64'(lane_valid), 64'd0);

    m = {};
    for (int i = 0; i < 50; i++) m.push_back(8'($urandom));
    send_msg(5, m, 1'b0);
    wait_idle();
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
